// File: rtl/pe_pkg.sv
// pe_pkg: shared definitions for the MAC processing element.
// Holds the 2-bit operating-mode type and its four encodings.
package pe_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t SINGLE   = 2'd0;  // local multiply-accumulate
    localparam mode_t LOAD     = 2'd1;  // capture a stationary weight
    localparam mode_t SYSTOLIC = 2'd2;  // psum_i + act_i * stored weight
    localparam mode_t IDLE     = 2'd3;  // hold everything

endpackage

// File: rtl/pe_mac_param_if.sv
// pe_mac_param_if: data/control bundle of one processing element.
//   mode_i, valid_i, act_i, wt_i, psum_i, clr_i : into the PE
//   act_o, valid_o, psum_o, out_valid_o, ovf_o  : out of the PE
// master = the driver of the PE (upstream logic / testbench), slave = the PE.
interface pe_mac_param_if
    import pe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
);
    mode_t                     mode_i;
    logic                      valid_i;
    logic signed [DATA_W-1:0]  act_i;
    logic signed [DATA_W-1:0]  wt_i;
    logic signed [ACC_W-1:0]   psum_i;
    logic                      clr_i;

    logic signed [DATA_W-1:0]  act_o;
    logic                      valid_o;
    logic signed [ACC_W-1:0]   psum_o;
    logic                      out_valid_o;
    logic                      ovf_o;

    modport master (
        output mode_i, valid_i, act_i, wt_i, psum_i, clr_i,
        input  act_o, valid_o, psum_o, out_valid_o, ovf_o
    );

    modport slave (
        input  mode_i, valid_i, act_i, wt_i, psum_i, clr_i,
        output act_o, valid_o, psum_o, out_valid_o, ovf_o
    );
endinterface

// File: rtl/pe_sat_add.sv
// pe_sat_add: W-bit signed adder with overflow detection.
//   a, b : signed addends
//   sum  : a + b, clamped to the signed range when SAT_EN != 0, wrapped otherwise
//   ovf  : the true result did not fit in W signed bits
module pe_sat_add #(
    parameter int W      = 20,
    parameter int SAT_EN = 1
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    output logic signed [W-1:0] sum,
    output logic                ovf
);
    logic signed [W:0] wide;

    // One guard bit: the exact sum differs from its W-bit truncation
    // exactly when the top two bits of the W+1-bit sum disagree.
    // NOTE: every output of an always_comb gets a value on every path
    // (defaults first), otherwise a latch is inferred.
    always_comb begin
        wide = {a[W-1], a} + {b[W-1], b};
        ovf  = wide[W] ^ wide[W-1];
        sum  = wide[W-1:0];
        if (ovf && (SAT_EN != 0)) begin
            // Sign of the exact result picks the rail.
            sum = wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
endmodule

// File: rtl/pe_mac_param.sv
// pe_mac_param: parameterised signed MAC processing element.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : pe_mac_param_if slave (mode/valid/act/wt/psum/clr in,
//         act/valid forward, psum result, out_valid, sticky ovf out)
// SINGLE accumulates act*wt locally, LOAD captures a stationary weight,
// SYSTOLIC adds act*weight onto psum_i, IDLE freezes the element.
module pe_mac_param
    import pe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int SAT_EN = 1
) (
    input  logic          clk,
    input  logic          rst,
    pe_mac_param_if.slave bus
);
    generate
        if (ACC_W < 2 * DATA_W) begin : g_width_check
            $error("pe_mac_param: ACC_W must be at least 2*DATA_W");
        end
    endgenerate

    logic signed [DATA_W-1:0]   wt_q;
    logic signed [ACC_W-1:0]    acc_q;

    logic                       do_single;
    logic                       do_load;
    logic                       do_sys;
    logic signed [DATA_W-1:0]   mul_b;
    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [ACC_W-1:0]    add_a;
    logic signed [ACC_W-1:0]    add_sum;
    logic                       add_ovf;

    // SINGLE and SYSTOLIC never happen in the same cycle, so one
    // multiplier and one adder serve both paths with muxed operands.
    always_comb begin
        do_single = bus.valid_i && (bus.mode_i == SINGLE);
        do_load   = bus.valid_i && (bus.mode_i == LOAD);
        do_sys    = bus.valid_i && (bus.mode_i == SYSTOLIC);
        mul_b     = do_single ? bus.wt_i : wt_q;
        prod      = bus.act_i * mul_b;
        prod_ext  = ACC_W'(prod);
        // Clear together with a SINGLE add starts the accumulator from zero.
        if (do_single) begin
            add_a = bus.clr_i ? '0 : acc_q;
        end else begin
            add_a = bus.psum_i;
        end
    end

    pe_sat_add #(
        .W      (ACC_W),
        .SAT_EN (SAT_EN)
    ) u_add (
        .a   (add_a),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.act_o       <= '0;
            bus.valid_o     <= 1'b0;
            bus.psum_o      <= '0;
            bus.out_valid_o <= 1'b0;
            bus.ovf_o       <= 1'b0;
            acc_q           <= '0;
            wt_q            <= '0;
        end else begin
            if (bus.mode_i != IDLE) begin
                bus.act_o   <= bus.act_i;
                bus.valid_o <= bus.valid_i;
            end

            bus.out_valid_o <= do_single || do_sys;

            if (do_load) begin
                wt_q       <= bus.wt_i;
                bus.psum_o <= ACC_W'(bus.wt_i);
            end

            if (do_single || do_sys) begin
                bus.psum_o <= add_sum;
                // A clear in the same cycle drops the old flag; only this add counts.
                bus.ovf_o  <= (bus.ovf_o && !bus.clr_i) || add_ovf;
            end else if (bus.clr_i) begin
                bus.ovf_o  <= 1'b0;
            end

            if (do_single) begin
                acc_q <= add_sum;
            end else if (bus.clr_i) begin
                acc_q <= '0;
            end
        end
    end
endmodule

// File: tb/tb_pe_mac_param.sv
// tb_pe_mac_param: three PEs share one directed stimulus stream:
//   dut0 defaults (ACC_W=20, saturating), dut1 ACC_W=16 saturating,
//   dut2 ACC_W=16 wrapping. An arithmetic model predicts every output of
//   each instance each cycle; literal checks pin the model to known answers.
module tb_pe_mac_param;
    import pe_pkg::*;

    logic                clk = 1'b0;
    logic                rst;
    mode_t               mode;
    logic                valid;
    logic                clr;
    logic signed [7:0]   act;
    logic signed [7:0]   wt;
    logic signed [19:0]  psum;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    pe_mac_param_if #(.DATA_W(8), .ACC_W(20)) if0 ();
    pe_mac_param_if #(.DATA_W(8), .ACC_W(16)) if1 ();
    pe_mac_param_if #(.DATA_W(8), .ACC_W(16)) if2 ();

    assign if0.mode_i = mode;  assign if1.mode_i = mode;  assign if2.mode_i = mode;
    assign if0.valid_i = valid; assign if1.valid_i = valid; assign if2.valid_i = valid;
    assign if0.clr_i = clr;    assign if1.clr_i = clr;    assign if2.clr_i = clr;
    assign if0.act_i = act;    assign if1.act_i = act;    assign if2.act_i = act;
    assign if0.wt_i = wt;      assign if1.wt_i = wt;      assign if2.wt_i = wt;
    assign if0.psum_i = psum;
    assign if1.psum_i = psum[15:0];
    assign if2.psum_i = psum[15:0];

    pe_mac_param #(.DATA_W(8), .ACC_W(20), .SAT_EN(1)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
    pe_mac_param #(.DATA_W(8), .ACC_W(16), .SAT_EN(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));
    pe_mac_param #(.DATA_W(8), .ACC_W(16), .SAT_EN(0)) dut2 (.clk(clk), .rst(rst), .bus(if2.slave));

    task automatic check(input string name, input longint actual, input longint expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        longint acc;
        longint wt;
        longint psum;
        bit     ov;
        bit     ovf;
    } model_t;

    model_t m[3];
    longint m_act_o;
    bit     m_valid_o;

    function automatic int acc_w_of(input int k);
        return (k == 0) ? 20 : 16;
    endfunction

    // Reinterpret the low w bits of v as a signed number.
    function automatic longint wrap(input longint v, input int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic void fit(input longint v, input int w, input bit sat,
                                output longint r, output bit o);
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -(longint'(1) <<< (w - 1));
        o = (v > hi) || (v < lo);
        if (!o)       r = v;
        else if (sat) r = (v > hi) ? hi : lo;
        else          r = wrap(v, w);
    endfunction

    function automatic model_t step(input model_t s, input int k);
        model_t n = s;
        int     w = acc_w_of(k);
        bit     sat = (k != 2);
        longint r;
        bit     o;
        n.ov = 1'b0;
        if (valid && mode == SINGLE) begin
            fit((clr ? 0 : s.acc) + longint'(act) * longint'(wt), w, sat, r, o);
            n.acc  = r;
            n.psum = r;
            n.ov   = 1'b1;
            n.ovf  = (clr ? 1'b0 : s.ovf) | o;
        end else begin
            if (clr) begin
                n.acc = 0;
                n.ovf = 1'b0;
            end
            if (valid && mode == LOAD) begin
                n.wt   = longint'(wt);
                n.psum = longint'(wt);
            end
            if (valid && mode == SYSTOLIC) begin
                fit(wrap(longint'(psum), w) + longint'(act) * s.wt, w, sat, r, o);
                n.psum = r;
                n.ov   = 1'b1;
                n.ovf  = n.ovf | o;
            end
        end
        return n;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) m[k] <= '{0, 0, 0, 1'b0, 1'b0};
            m_act_o   <= 0;
            m_valid_o <= 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) m[k] <= step(m[k], k);
            if (mode != IDLE) begin
                m_act_o   <= longint'(act);
                m_valid_o <= valid;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("dut0.act_o",       longint'(if0.act_o),  m_act_o);
        check("dut0.valid_o",     longint'(if0.valid_o), longint'(m_valid_o));
        check("dut0.psum_o",      longint'(if0.psum_o), m[0].psum);
        check("dut0.out_valid_o", longint'(if0.out_valid_o), longint'(m[0].ov));
        check("dut0.ovf_o",       longint'(if0.ovf_o),  longint'(m[0].ovf));
        check("dut1.act_o",       longint'(if1.act_o),  m_act_o);
        check("dut1.psum_o",      longint'(if1.psum_o), m[1].psum);
        check("dut1.out_valid_o", longint'(if1.out_valid_o), longint'(m[1].ov));
        check("dut1.ovf_o",       longint'(if1.ovf_o),  longint'(m[1].ovf));
        check("dut2.valid_o",     longint'(if2.valid_o), longint'(m_valid_o));
        check("dut2.psum_o",      longint'(if2.psum_o), m[2].psum);
        check("dut2.out_valid_o", longint'(if2.out_valid_o), longint'(m[2].ov));
        check("dut2.ovf_o",       longint'(if2.ovf_o),  longint'(m[2].ovf));
    end

    // ---------------- directed stimulus ----------------
    task automatic cycle(input mode_t md, input logic v, input int a, input int w,
                         input int p, input logic c);
        mode  = md;
        valid = v;
        act   = 8'(a);
        wt    = 8'(w);
        psum  = 20'(p);
        clr   = c;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " psum_o"},      longint'(if0.psum_o) | longint'(if1.psum_o) | longint'(if2.psum_o), 0);
        check({tag, " act_o"},       longint'(if0.act_o), 0);
        check({tag, " valid_o"},     longint'(if0.valid_o), 0);
        check({tag, " out_valid_o"}, longint'(if0.out_valid_o), 0);
        check({tag, " ovf_o"},       longint'(if0.ovf_o | if1.ovf_o | if2.ovf_o), 0);
    endtask

    initial begin
        rst = 1'b1;
        mode = IDLE; valid = 1'b0; clr = 1'b0; act = '0; wt = '0; psum = '0;
        #2;
        check_all_zero("reset");
        @(negedge clk);
        #1;
        rst = 1'b0;

        // Stationary weight 3, then one systolic step: 10 + 5*3.
        cycle(LOAD, 1, 0, 3, 0, 0);
        check("load psum_o", longint'(if0.psum_o), 3);
        check("load out_valid_o", longint'(if0.out_valid_o), 0);
        cycle(SYSTOLIC, 1, 5, 0, 10, 0);
        check("systolic psum_o", longint'(if0.psum_o), 25);
        check("systolic out_valid_o", longint'(if0.out_valid_o), 1);
        cycle(IDLE, 0, 0, 0, 0, 0);

        // Local accumulation 6, 2, -8; clear; restart at 1.
        cycle(SINGLE, 1, 2, 3, 0, 0);
        check("single #1", longint'(if0.psum_o), 6);
        cycle(SINGLE, 1, 4, -1, 0, 0);
        check("single #2", longint'(if0.psum_o), 2);
        cycle(SINGLE, 1, -5, 2, 0, 0);
        check("single #3", longint'(if0.psum_o), -8);
        cycle(IDLE, 0, 0, 0, 0, 1);
        cycle(SINGLE, 1, 1, 1, 0, 0);
        check("single after clr", longint'(if0.psum_o), 1);

        // IDLE freezes forwarding and result; detour through SYSTOLIC keeps acc.
        cycle(IDLE, 1, 9, 4, 0, 0);
        check("idle act_o", longint'(if0.act_o), 1);
        check("idle valid_o", longint'(if0.valid_o), 1);
        check("idle psum_o", longint'(if0.psum_o), 1);
        check("idle out_valid_o", longint'(if0.out_valid_o), 0);
        cycle(SYSTOLIC, 1, 2, 0, 100, 0);
        check("detour systolic", longint'(if0.psum_o), 106);
        cycle(SINGLE, 1, 1, 1, 0, 0);
        check("acc resumed", longint'(if0.psum_o), 2);

        // Positive overflow: 16129 per step.
        cycle(LOAD, 0, 0, 0, 0, 1);
        cycle(SINGLE, 1, 127, 127, 0, 0);
        check("sat16 #1", longint'(if1.psum_o), 16129);
        cycle(SINGLE, 1, 127, 127, 0, 0);
        check("sat16 #2", longint'(if1.psum_o), 32258);
        check("sat16 ovf before", longint'(if1.ovf_o), 0);
        cycle(SINGLE, 1, 127, 127, 0, 0);
        check("sat16 #3", longint'(if1.psum_o), 32767);
        check("sat16 ovf", longint'(if1.ovf_o), 1);
        check("wrap16 #3", longint'(if2.psum_o), -17149);
        check("wrap16 ovf", longint'(if2.ovf_o), 1);
        check("acc20 #3", longint'(if0.psum_o), 48387);
        check("acc20 ovf", longint'(if0.ovf_o), 0);
        cycle(SINGLE, 0, 0, 0, 0, 0);
        check("ovf sticky", longint'(if1.ovf_o), 1);
        // Clear-and-load: accumulator restarts at the product, flag drops.
        cycle(SINGLE, 1, 7, 2, 0, 1);
        check("clr+single psum_o", longint'(if1.psum_o), 14);
        check("clr+single ovf_o", longint'(if1.ovf_o | if2.ovf_o), 0);

        // Negative overflow: -16256 per step, starting from clear.
        cycle(IDLE, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(SINGLE, 1, -128, 127, 0, 0);
        check("sat16 neg", longint'(if1.psum_o), -32768);
        check("wrap16 neg", longint'(if2.psum_o), 16768);
        cycle(IDLE, 1, 0, 0, 0, 1);
        check("clr in idle", longint'(if1.ovf_o), 0);

        // Systolic overflow on the 16-bit parts: 30000 + 127*127.
        cycle(LOAD, 1, 0, 127, 0, 0);
        cycle(SYSTOLIC, 1, 127, 0, 30000, 0);
        check("sys sat16", longint'(if1.psum_o), 32767);
        check("sys wrap16", longint'(if2.psum_o), -19407);
        check("sys acc20", longint'(if0.psum_o), 46129);
        check("sys ovf16", longint'(if2.ovf_o), 1);

        // Asynchronous reset in the middle of an accumulation.
        cycle(SINGLE, 1, 3, 3, 0, 1);
        cycle(SINGLE, 1, 3, 3, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async reset");
        #2;
        rst = 1'b0;
        cycle(SINGLE, 1, 7, 2, 0, 1);
        check("post-reset clr+single", longint'(if0.psum_o), 14);
        check("post-reset out_valid", longint'(if0.out_valid_o), 1);
        cycle(SYSTOLIC, 1, 4, 0, 5, 0);
        check("post-reset weight cleared", longint'(if0.psum_o), 5);
        cycle(IDLE, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
